// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with mid-bit sampling and a small receive FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int DIVISOR    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int          c_AW   = $clog2(FIFO_DEPTH);
    localparam logic [15:0] c_HALF = 16'(DIVISOR / 2 - 1);
    localparam logic [15:0] c_FULL = 16'(DIVISOR - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;
    localparam logic [2:0] c_BREAK = 3'd4;

    logic [1:0]  r_sync;
    logic        w_rxs;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_frame_err;
    logic        r_overrun;
    logic        w_tick;
    logic        w_push;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rxs  = r_sync[1];
    assign w_tick = (r_cnt == 16'd0);
    assign w_push = (r_state == c_STOP) && w_tick && w_rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= 16'd0;
            r_idx       <= 3'd0;
            r_shift     <= 8'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= c_START;
                        r_cnt   <= c_HALF;
                    end
                end
                c_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (!w_rxs) begin
                        r_state <= c_DATA;
                        r_cnt   <= c_FULL;
                        r_idx   <= 3'd0;
                    end else begin
                        // Start bit vanished by mid-bit: treat as line noise.
                        r_state <= c_IDLE;
                    end
                end
                c_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_shift[r_idx] <= w_rxs;
                        r_cnt          <= c_FULL;
                        if (r_idx == 3'd7) begin
                            r_state <= c_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                c_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (w_rxs) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_BREAK;
                    end
                end
                c_BREAK: begin
                    if (w_rxs) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = !w_empty && ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            if (w_wr_en) begin
                r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign data      = r_mem[r_rd_ptr[c_AW-1:0]];
    assign valid     = !w_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: Parameter DIVISOR, default 868, gives clock cycles per bit (100 MHz / 115200); legal range 4..65535.
- REQ-002: Parameter FIFO_DEPTH, default 4, gives receive FIFO entries; must be a power of two, 2..16.
- REQ-003: Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-004: Port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005: Port rx, input, 1 bit: asynchronous serial line, 8N1, LSB first, idle high.
- REQ-006: Port data, output, 8 bits: FIFO head byte; valid only while valid=1.
- REQ-007: Port valid, output, 1 bit: FIFO not empty.
- REQ-008: Port ready, input, 1 bit: consumer accepts head when valid&&ready.
- REQ-009: Port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
- REQ-010: Port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the FIFO is full.
- REQ-011: Port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
- REQ-012: rx shall pass through a 2-flop synchronizer, both flops reset to 1; all logic below uses the synchronized value rxs.
- REQ-013: FSM states are IDLE, START, DATA, STOP and BREAK; a single down-counter (16 bits) and a bit index (3 bits) serve all states.
- REQ-014: IDLE: when rxs=0, go to START and load counter = DIVISOR/2 - 1 (integer division).
- REQ-015: START: at counter=0, sample rxs. If 0, go to DATA, load DIVISOR-1 and index 0. If 1, return to IDLE silently (glitch reject, no error pulse).
- REQ-016: DATA: at each counter=0, shift rxs into bit[index] (LSB first) and reload DIVISOR-1. After index 7, go to STOP.
- REQ-017: STOP: at counter=0, sample rxs. If 1, push the byte and go to IDLE in the same edge. If 0, pulse frame_err, discard the byte and go to BREAK.
- REQ-018: BREAK: stay until rxs=1, then go to IDLE; a held-low line produces exactly one frame_err.
- REQ-019: Push with FIFO full and no simultaneous pop: drop the byte, pulse overrun, leave FIFO contents unchanged.
- REQ-020: Push and pop in the same cycle shall both succeed, including when full (no overrun) and when empty-then-push (the pop is not legal because valid=0).
- REQ-021: Latency: valid/data reflect a pushed byte on the cycle after the STOP sample edge.
- REQ-022: Pop on valid&&ready; data advances to the next entry on the following cycle; data and valid are driven from registered FIFO state (no combinational path from rx).
- REQ-023: FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Full = MSBs differ and the rest are equal; empty = pointers equal.
- REQ-024: A new start bit is detectable on the first cycle in IDLE; back-to-back frames with no extra idle time shall be received without loss.

Reset
- REQ-025: While rst_n=0: FSM=IDLE, counter=0, index=0, shift register=0, FIFO pointers=0, synchronizer flops=1, valid=0, data=0, frame_err=0, overrun=0, busy=0.
- REQ-026: Reset asserted mid-frame aborts the frame and discards FIFO contents; after release, reception starts only on a new rxs=0 seen in IDLE.

Verification (DIVISOR=16, FIFO_DEPTH=4)
- REQ-027: Send 0xA5 at 16 clk/bit with ready=1 -> valid for exactly 1 cycle, data=0xA5, no error pulses, busy low after stop.
- REQ-028: Send 0x55 with the stop bit driven 0, then hold rx low for 40 bits -> exactly one frame_err pulse, valid stays 0, busy stays high until rx returns to 1.
- REQ-029: Send a 5-clk low glitch on idle rx -> START rejects it, no valid, no frame_err, busy returns to 0 within 10 cycles.
- REQ-030: ready=0, send 0x01..0x05 back-to-back -> FIFO holds 0x01..0x04, one overrun pulse on the 5th byte; then ready=1 pops 0x01,0x02,0x03,0x04 in order on consecutive cycles.
- REQ-031: FIFO full, ready asserted on the exact cycle of the 5th stop-bit push -> no overrun, final pop sequence 0x02..0x05.
- REQ-032: Drop rst_n to 0 during DATA of a frame, release it, then send 0x3C -> only 0x3C is received, with no error pulses.
